// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the LEGv8 datapath/memories.
// master: the controller (consumes IR/flags/ready, drives strobes and status).
// slave:  the datapath side (drives IR/flags/ready, consumes strobes and status).
interface multicycle_ctrl_if #(
    parameter int RET_W = 32
);
    logic [10:0]      Op;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCSrc;
    logic             Reg2Loc;
    logic             ALUSrc;
    logic             MemtoReg;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic [1:0]       ALUOp;
    logic             illegal;
    logic             timeout;
    logic [RET_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  Op, zero, imem_ready, dmem_ready,
        output imem_req, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg,
               RegWrite, MemRead, MemWrite, ALUOp, illegal, timeout, retired, state
    );

    modport slave (
        output Op, zero, imem_ready, dmem_ready,
        input  imem_req, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg,
               RegWrite, MemRead, MemWrite, ALUOp, illegal, timeout, retired, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback,
// guards memory waits with a timeout and counts retired instructions.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | request instruction; load IR and PC+4 when imem is ready
// DECODE  | classify opcode, pick the execute path
// EX_R    | R-type ALU operation
// WB_R    | write ALU result to register file
// EX_ADDR | compute load/store address
// MEM_RD  | data memory read, waits for dmem_ready
// WB_LD   | write loaded data to register file
// MEM_WR  | data memory write, waits for dmem_ready
// EX_CBZ  | zero test; branch to target when zero
// ERROR   | trapped (illegal opcode or memory timeout) until reset
module multicycle_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int RET_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_if.master     bus
);
    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EX_R    = 4'd2,
        WB_R    = 4'd3,
        EX_ADDR = 4'd4,
        MEM_RD  = 4'd5,
        WB_LD   = 4'd6,
        MEM_WR  = 4'd7,
        EX_CBZ  = 4'd8,
        ERROR   = 4'd9
    } state_t;

    state_t           cur_state;
    state_t           next_state;
    logic [CW-1:0]    wait_cnt;
    logic [RET_W-1:0] ret_cnt;
    logic             ill_flag;
    logic             to_flag;

    logic is_ldur, is_stur, is_cbz, is_rtype;
    logic wait_state, ready_now, retire, set_ill, set_to;

    logic imem_req_c, ir_write_c, pc_write_c, pc_src_c, reg2loc_c, alu_src_c;
    logic mem_to_reg_c, reg_write_c, mem_read_c, mem_write_c;
    logic [1:0] alu_op_c;

    // Opcode classification from the IR opcode field.
    always_comb begin
        is_ldur  = (bus.Op == 11'b11111000010);
        is_stur  = (bus.Op == 11'b11111000000);
        is_cbz   = (bus.Op[10:3] == 8'b10110100);
        is_rtype = (bus.Op == 11'b10001011000) || (bus.Op == 11'b11001011000) ||
                   (bus.Op == 11'b10001010000) || (bus.Op == 11'b10101010000);
    end

    // Next-state, strobes and event pulses for the current state.
    always_comb begin
        next_state   = cur_state;
        imem_req_c   = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        reg2loc_c    = 1'b0;
        alu_src_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        alu_op_c     = 2'b00;
        wait_state   = 1'b0;
        ready_now    = 1'b1;
        retire       = 1'b0;
        set_ill      = 1'b0;
        set_to       = 1'b0;
        unique case (cur_state)
            FETCH: begin
                imem_req_c = 1'b1;
                wait_state = 1'b1;
                ready_now  = bus.imem_ready;
                if (bus.imem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    next_state = DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = ERROR;
                    set_to     = 1'b1;
                end
            end
            DECODE: begin
                if (is_ldur || is_stur) begin
                    next_state = EX_ADDR;
                end else if (is_rtype) begin
                    next_state = EX_R;
                end else if (is_cbz) begin
                    next_state = EX_CBZ;
                end else begin
                    next_state = ERROR;
                    set_ill    = 1'b1;
                end
            end
            EX_R: begin
                alu_op_c   = 2'b10;
                next_state = WB_R;
            end
            WB_R: begin
                alu_op_c    = 2'b10;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                next_state  = FETCH;
            end
            EX_ADDR: begin
                alu_src_c  = 1'b1;
                reg2loc_c  = is_stur;
                next_state = is_stur ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                alu_src_c  = 1'b1;
                mem_read_c = 1'b1;
                wait_state = 1'b1;
                ready_now  = bus.dmem_ready;
                if (bus.dmem_ready) begin
                    next_state = WB_LD;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = ERROR;
                    set_to     = 1'b1;
                end
            end
            WB_LD: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                retire       = 1'b1;
                next_state   = FETCH;
            end
            MEM_WR: begin
                alu_src_c   = 1'b1;
                reg2loc_c   = 1'b1;
                mem_write_c = 1'b1;
                wait_state  = 1'b1;
                ready_now   = bus.dmem_ready;
                if (bus.dmem_ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = ERROR;
                    set_to     = 1'b1;
                end
            end
            EX_CBZ: begin
                reg2loc_c  = 1'b1;
                alu_op_c   = 2'b01;
                pc_write_c = bus.zero;
                pc_src_c   = bus.zero;
                retire     = 1'b1;
                next_state = FETCH;
            end
            ERROR: begin
                next_state = ERROR;
            end
            default: begin
                next_state = ERROR;
            end
        endcase
    end

    // State register, wait counter, retire counter and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            wait_cnt  <= '0;
            ret_cnt   <= '0;
            ill_flag  <= 1'b0;
            to_flag   <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (next_state != cur_state) begin
                wait_cnt <= '0;
            end else if (wait_state && !ready_now) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (retire) begin
                ret_cnt <= ret_cnt + RET_W'(1);
            end
            if (set_ill) begin
                ill_flag <= 1'b1;
            end
            if (set_to) begin
                to_flag <= 1'b1;
            end
        end
    end

    assign bus.imem_req = imem_req_c;
    assign bus.IRWrite  = ir_write_c;
    assign bus.PCWrite  = pc_write_c;
    assign bus.PCSrc    = pc_src_c;
    assign bus.Reg2Loc  = reg2loc_c;
    assign bus.ALUSrc   = alu_src_c;
    assign bus.MemtoReg = mem_to_reg_c;
    assign bus.RegWrite = reg_write_c;
    assign bus.MemRead  = mem_read_c;
    assign bus.MemWrite = mem_write_c;
    assign bus.ALUOp    = alu_op_c;
    assign bus.illegal  = ill_flag;
    assign bus.timeout  = to_flag;
    assign bus.retired  = ret_cnt;
    assign bus.state    = cur_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into an expected
// per-cycle trace from its class and memory wait counts, then replayed.
module tb_multicycle_ctrl;
    localparam int MAX_WAIT = 16;
    localparam int RET_W    = 32;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_ILL = 4;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXR = 4'd2, S_WBR = 4'd3,
                           S_EXA = 4'd4, S_MRD = 4'd5, S_WBLD = 4'd6, S_MWR = 4'd7,
                           S_CBZ = 4'd8, S_ERR = 4'd9;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    typedef struct packed {
        logic        ir;
        logic        dr;
        logic        z;
        logic [10:0] op;
        logic [3:0]  st;
        logic [11:0] ctl;
        logic [31:0] ret;
        logic        ill;
        logic        to;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.RET_W(RET_W)) bus();

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .RET_W(RET_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    step_t       plan[$];
    logic [31:0] m_ret;
    bit          m_ill;
    bit          m_to;
    logic [10:0] m_op;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic int classify(input logic [10:0] op);
        if (op == OP_LDUR) return K_LD;
        if (op == OP_STUR) return K_ST;
        if (op[10:3] == 8'b10110100) return K_CBZ;
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return K_R;
        return K_ILL;
    endfunction

    // Packs a control word: {imem_req,IRWrite,PCWrite,PCSrc,Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp}
    function automatic logic [11:0] cw(input bit imr, input bit irw, input bit pcw, input bit pcs,
                                       input bit r2l, input bit als, input bit m2r, input bit rw,
                                       input bit mr, input bit mw, input logic [1:0] aop);
        return {imr, irw, pcw, pcs, r2l, als, m2r, rw, mr, mw, aop};
    endfunction

    task automatic push(input logic [3:0] st, input logic [11:0] c, input bit ir, input bit dr, input bit z);
        step_t s;
        s.ir = ir; s.dr = dr; s.z = z; s.op = m_op; s.st = st; s.ctl = c;
        s.ret = m_ret; s.ill = m_ill; s.to = m_to;
        plan.push_back(s);
    endtask

    // w cycles of ready low then one ready-high cycle, unless the wait budget runs out first.
    task automatic wait_phase(input logic [3:0] st, input int w, input logic [11:0] c_lo,
                              input logic [11:0] c_hi, input bit is_fetch, output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (is_fetch) push(st, c_lo, 1'b0, rb(), rb());
            else          push(st, c_lo, rb(), 1'b0, rb());
            if (i == MAX_WAIT - 1) begin
                m_to    = 1'b1;
                trapped = 1'b1;
                return;
            end
        end
        if (is_fetch) push(st, c_hi, 1'b1, rb(), rb());
        else          push(st, c_hi, rb(), 1'b1, rb());
    endtask

    task automatic plan_instr(input logic [10:0] op, input int wf, input int wd, input bit z,
                              output bit trapped);
        int k;
        m_op = op;
        k = classify(op);
        wait_phase(S_FETCH, wf, cw(1,0,0,0,0,0,0,0,0,0,2'b00), cw(1,1,1,0,0,0,0,0,0,0,2'b00), 1'b1, trapped);
        if (trapped) return;
        push(S_DECODE, 12'h000, rb(), rb(), rb());
        case (k)
            K_R: begin
                push(S_EXR, cw(0,0,0,0,0,0,0,0,0,0,2'b10), rb(), rb(), rb());
                push(S_WBR, cw(0,0,0,0,0,0,0,1,0,0,2'b10), rb(), rb(), rb());
                m_ret++;
            end
            K_LD: begin
                push(S_EXA, cw(0,0,0,0,0,1,0,0,0,0,2'b00), rb(), rb(), rb());
                wait_phase(S_MRD, wd, cw(0,0,0,0,0,1,0,0,1,0,2'b00), cw(0,0,0,0,0,1,0,0,1,0,2'b00), 1'b0, trapped);
                if (trapped) return;
                push(S_WBLD, cw(0,0,0,0,0,0,1,1,0,0,2'b00), rb(), rb(), rb());
                m_ret++;
            end
            K_ST: begin
                push(S_EXA, cw(0,0,0,0,1,1,0,0,0,0,2'b00), rb(), rb(), rb());
                wait_phase(S_MWR, wd, cw(0,0,0,0,1,1,0,0,0,1,2'b00), cw(0,0,0,0,1,1,0,0,0,1,2'b00), 1'b0, trapped);
                if (trapped) return;
                m_ret++;
            end
            K_CBZ: begin
                push(S_CBZ, cw(0,0,z,z,1,0,0,0,0,0,2'b01), rb(), rb(), z);
                m_ret++;
            end
            default: begin
                m_ill   = 1'b1;
                trapped = 1'b1;
            end
        endcase
    endtask

    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.imem_ready = s.ir;
            bus.dmem_ready = s.dr;
            bus.zero       = s.z;
            bus.Op         = s.op;
            @(negedge clk);
            check("state", 64'(bus.state), 64'(s.st));
            check("ctl", 64'({bus.imem_req, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.Reg2Loc,
                              bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
                              bus.MemWrite, bus.ALUOp}), 64'(s.ctl));
            check("retired", 64'(bus.retired), 64'(s.ret));
            check("illegal", 64'(bus.illegal), 64'(s.ill));
            check("timeout", 64'(bus.timeout), 64'(s.to));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic error_hold(input int n);
        for (int i = 0; i < n; i++) push(S_ERR, 12'h000, rb(), rb(), rb());
        run_plan();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ret = '0;
        m_ill = 1'b0;
        m_to  = 1'b0;
        check("rst_state", 64'(bus.state), 64'(S_FETCH));
        check("rst_retired", 64'(bus.retired), 64'd0);
        check("rst_illegal", 64'(bus.illegal), 64'd0);
        check("rst_timeout", 64'(bus.timeout), 64'd0);
        check("rst_memwrite", 64'(bus.MemWrite), 64'd0);
        check("rst_imem_req", 64'(bus.imem_req), 64'd1);
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return int'($urandom_range(0, 2));
        if (r < 8) return int'($urandom_range(3, MAX_WAIT - 2));
        return int'($urandom_range(MAX_WAIT - 1, MAX_WAIT + 1));
    endfunction

    function automatic logic [10:0] pick_op();
        logic [10:0] op;
        case ($urandom_range(0, 7))
            0: op = OP_ADD;
            1: op = OP_SUB;
            2: op = OP_AND;
            3: op = OP_ORR;
            4: op = OP_LDUR;
            5: op = OP_STUR;
            6: op = {8'b10110100, 3'($urandom_range(0, 7))};
            default: begin
                do op = 11'($urandom); while (classify(op) != K_ILL);
            end
        endcase
        return op;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit tr;
        logic [10:0] op;
        reset = 1'b1;
        bus.Op = '0;
        bus.zero = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        m_ret = '0; m_ill = 1'b0; m_to = 1'b0; m_op = '0;
        do_reset();

        plan_instr(OP_ADD, 0, 0, 1'b0, tr);            run_plan();
        plan_instr(OP_LDUR, 0, 3, 1'b0, tr);           run_plan();
        plan_instr(11'b10110100010, 0, 0, 1'b1, tr);   run_plan();
        plan_instr(11'b10110100010, 0, 0, 1'b0, tr);   run_plan();
        plan_instr(OP_STUR, 2, MAX_WAIT - 1, 1'b0, tr); run_plan();
        plan_instr(OP_SUB, MAX_WAIT - 1, 0, 1'b0, tr);  run_plan();

        plan_instr(11'b11111111111, 0, 0, 1'b0, tr);   run_plan();
        error_hold(20);
        do_reset();

        plan_instr(OP_ADD, MAX_WAIT, 0, 1'b0, tr);     run_plan();
        error_hold(3);
        do_reset();

        plan_instr(OP_LDUR, 1, MAX_WAIT, 1'b0, tr);    run_plan();
        error_hold(3);
        do_reset();

        // Reset arriving in the middle of a stalled store.
        plan_instr(OP_ORR, 0, 0, 1'b0, tr);            run_plan();
        m_op = OP_STUR;
        push(S_FETCH, cw(1,1,1,0,0,0,0,0,0,0,2'b00), 1'b1, 1'b0, 1'b0);
        push(S_DECODE, 12'h000, 1'b0, 1'b0, 1'b0);
        push(S_EXA, cw(0,0,0,0,1,1,0,0,0,0,2'b00), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(S_MWR, cw(0,0,0,0,1,1,0,0,0,1,2'b00), 1'b0, 1'b0, 1'b0);
        run_plan();
        do_reset();

        for (int n = 0; n < 80; n++) begin
            op = pick_op();
            plan_instr(op, pick_wait(), pick_wait(), rb(), tr);
            run_plan();
            if (tr) begin
                error_hold(2);
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM for the LEGv8 datapath, replacing the single-cycle main decoder's one-shot control word with a per-state sequence. It decodes the 11-bit opcode held in the instruction register and steps through fetch, decode, execute, memory and writeback. It handshakes with instruction and data memory, enforces a memory wait timeout, and counts retired instructions. It sits between the IR/flags and the PC, register file, ALU and memory enables.

Parameters:
MAX_WAIT, 16, maximum cycles any memory wait state may hold with ready low before the FSM traps to ERROR (legal range ≥2).
RET_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
Op  in  11  opcode field, IR[31:21]; valid from DECODE onward.
zero  in  1  ALU zero flag.
imem_ready  in  1  instruction memory has data this cycle.
dmem_ready  in  1  data memory completes the access this cycle.
imem_req  out  1  instruction fetch request.
IRWrite  out  1  load IR.
PCWrite  out  1  update PC.
PCSrc  out  1  0 = PC+4, 1 = branch target (computed from the latched old PC).
Reg2Loc  out  1  register read port 2 select.
ALUSrc  out  1  ALU B operand: 0 = register, 1 = sign-extended immediate.
MemtoReg  out  1  writeback source: 1 = memory.
RegWrite  out  1  register file write enable.
MemRead  out  1  data memory read strobe.
MemWrite  out  1  data memory write strobe.
ALUOp  out  2  00 add, 01 pass-B/zero test, 10 funct decode.
illegal  out  1  sticky: unsupported opcode seen.
timeout  out  1  sticky: memory wait exceeded MAX_WAIT.
retired  out  RET_W  count of completed instructions; wraps modulo 2^RET_W.
state  out  4  current state encoding, for debug.

Behaviour:
- Opcode decode:
  - LDUR = 11111000010.
  - STUR = 11111000000.
  - CBZ = Op[10:3] == 10110100.
  - ADD = 10001011000, SUB = 11001011000, AND = 10001010000, ORR = 10101010000.
  - All other opcodes are illegal.
- State encoding: FETCH=0, DECODE=1, EX_R=2, WB_R=3, EX_ADDR=4, MEM_RD=5, WB_LD=6, MEM_WR=7, EX_CBZ=8, ERROR=9.
- Reset:
  - state=FETCH; retired=0; illegal=0; timeout=0; wait counter=0.
  - Reset overrides every state, including mid-wait and ERROR.
- Default outputs: every strobe is 0 unless listed below. ALUOp and Reg2Loc default to 00 and 0.
- FETCH:
  - imem_req=1.
  - If imem_ready: IRWrite=1, PCWrite=1, PCSrc=0 (these three are Mealy, same cycle); next state DECODE.
- DECODE (no strobes):
  - LDUR or STUR -> EX_ADDR.
  - R-type -> EX_R.
  - CBZ -> EX_CBZ.
  - Illegal -> ERROR; illegal is set on the transition edge.
- EX_R: Reg2Loc=0, ALUSrc=0, ALUOp=10; next WB_R.
- WB_R: ALUOp=10, RegWrite=1, MemtoReg=0; next FETCH; retired+1.
- EX_ADDR:
  - ALUSrc=1, ALUOp=00, Reg2Loc=1 if STUR.
  - Next MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: ALUSrc=1, ALUOp=00, MemRead=1, held until dmem_ready; then next WB_LD.
- WB_LD: MemtoReg=1, RegWrite=1; next FETCH; retired+1.
- MEM_WR:
  - ALUSrc=1, ALUOp=00, Reg2Loc=1, MemWrite=1, held until dmem_ready.
  - Then next FETCH; retired+1 on that edge.
- EX_CBZ:
  - Reg2Loc=1, ALUSrc=0, ALUOp=01.
  - If zero: PCWrite=1, PCSrc=1 (Mealy).
  - Next FETCH; retired+1 whether or not the branch is taken.
- ERROR:
  - All strobes 0, imem_req=0.
  - Holds until reset; illegal and timeout stay sticky.
- Wait counter (FETCH, MEM_RD, MEM_WR only):
  - Cleared on entry to any state.
  - Increments each cycle ready is low.
  - If ready is low in the cycle where the counter == MAX_WAIT-1: next ERROR, timeout=1.
  - Ready high in that same cycle wins, and the FSM proceeds normally.
- Latency with zero wait:
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
- Never assert MemRead and MemWrite together. Never assert RegWrite in a memory wait state.

Test Plan:
- Reset, then ADD (10001011000) with imem_ready and dmem_ready tied 1 -> state sequence 0,1,2,3,0; RegWrite high exactly in state 3; retired=1 after 4 cycles.
- LDUR with dmem_ready low for 3 cycles in MEM_RD -> MemRead held for 4 cycles; then WB_LD with MemtoReg=1 and RegWrite=1; retired increments once; timeout=0.
- CBZ (10110100010) once with zero=1, once with zero=0 -> taken: PCWrite=1 and PCSrc=1 in EX_CBZ; not taken: PCWrite=0; retired +1 in both cases.
- Op=11111111111 -> DECODE->ERROR; illegal=1; all strobes 0 for 20 cycles; reset returns to FETCH with illegal=0.
- MAX_WAIT=16, imem_ready held low -> ERROR entered on the 16th FETCH cycle with timeout=1. Repeat with imem_ready rising exactly on cycle 16 -> DECODE entered, no timeout.
- Assert reset during MEM_WR with dmem_ready low -> next cycle state=FETCH, MemWrite=0, retired=0.
